// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// The chain length and word width are parameters, so word counts are derived here.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Number of configuration words needed to cover the whole chain.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Unused low-order bits of the final word.
    function automatic int pad_bits(input int chain_len, input int word_w);
        return num_words(chain_len, word_w) * word_w - chain_len;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream (valid/ready) and readback word strobe between
// the bitstream loader (master) and the chain loader (slave).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  rb_data,
        input  rb_valid
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output rb_data,
        output rb_valid
    );
endinterface

// File: rtl/ccff_rb_packer.sv
// Collects the bits leaving the chain tail into MSB-first readback words;
// flush emits the final partial word left-justified and zero-filled.
module ccff_rb_packer #(
    parameter int WORD_W = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clear,
    input  logic              capture,
    input  logic              bit_in,
    input  logic              flush,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_W - 1);

    logic [WORD_W-2:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_next;

    // shreg only ever holds cnt valid bits in its low end, the rest stay zero.
    assign word_next = {shreg, bit_in};

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shreg    <= '0;
            cnt      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (capture) begin
                if (cnt == LAST_POS || flush) begin
                    rb_data  <= word_next << (LAST_POS - cnt);
                    rb_valid <= 1'b1;
                    shreg    <= '0;
                    cnt      <= '0;
                end else begin
                    shreg <= word_next[WORD_W-2:0];
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a tile's ccff chain from a word stream, one bit per enabled prog_clk
// edge, and returns the previous chain contents as readback words.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 19,
    parameter int WORD_W    = 16
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic               start,
    input  logic               abort,
    ccff_chain_loader_if.slave cfg,
    output logic               ccff_head,
    output logic               chain_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done
);
    localparam int N_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int BC_W    = $clog2(CHAIN_LEN + 1);
    localparam int BW_W    = $clog2(WORD_W);
    localparam int WC_W    = $clog2(N_WORDS + 1);

    localparam logic [BC_W-1:0] LAST_CHAIN_BIT = BC_W'(CHAIN_LEN - 1);
    localparam logic [BC_W-1:0] CHAIN_END      = BC_W'(CHAIN_LEN);
    localparam logic [BW_W-1:0] LAST_WORD_BIT  = BW_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] FINAL_WORD     = WC_W'(N_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] word_buf;
    logic [BC_W-1:0]   bit_cnt;
    logic [BW_W-1:0]   bit_in_word;
    logic [WC_W-1:0]   word_cnt;
    logic              load_word;
    logic              shift_bit;
    logic              clear_cnt;
    logic              last_chain_bit;
    logic              last_word_bit;
    logic              final_word;

    assign last_chain_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CHAIN_BIT);
    assign last_word_bit  = (bit_in_word == LAST_WORD_BIT);
    assign final_word     = (word_cnt == FINAL_WORD);

    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        shift_bit = 1'b0;
        clear_cnt = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_WAIT_WORD;
                        clear_cnt = 1'b1;
                    end
                end
                ST_WAIT_WORD: begin
                    if (cfg.cfg_valid) begin
                        state_nxt = ST_SHIFT;
                        load_word = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shift_bit = 1'b1;
                    if (last_chain_bit) begin
                        state_nxt = ST_DONE;
                    end else if (last_word_bit && !final_word) begin
                        state_nxt = ST_WAIT_WORD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // chain_shift_en is a dedicated flop so the integrator can gate prog_clk glitch-free.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            word_buf       <= '0;
            chain_shift_en <= 1'b0;
            bit_cnt        <= '0;
            bit_in_word    <= '0;
            word_cnt       <= '0;
        end else begin
            chain_shift_en <= (state_nxt == ST_SHIFT);

            if (load_word) begin
                word_buf <= cfg.cfg_data;
            end else if (shift_bit) begin
                word_buf <= {word_buf[WORD_W-2:0], 1'b0};
            end

            if (clear_cnt) begin
                bit_cnt     <= '0;
                bit_in_word <= '0;
                word_cnt    <= '0;
            end else if (shift_bit) begin
                if (bit_cnt != CHAIN_END) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (last_word_bit) begin
                    bit_in_word <= '0;
                    word_cnt    <= word_cnt + 1'b1;
                end else begin
                    bit_in_word <= bit_in_word + 1'b1;
                end
            end
        end
    end

    assign ccff_head     = word_buf[WORD_W-1];
    assign cfg.cfg_ready = (state == ST_WAIT_WORD);
    assign busy          = (state == ST_WAIT_WORD) || (state == ST_SHIFT);
    assign done          = (state == ST_DONE);

    // A partial readback word is dropped on abort: clear overrides the flush.
    ccff_rb_packer #(
        .WORD_W(WORD_W)
    ) u_rb_packer (
        .prog_clk(prog_clk),
        .pReset  (pReset),
        .clear   (clear_cnt | abort),
        .capture (chain_shift_en),
        .bit_in  (ccff_tail),
        .flush   (last_chain_bit),
        .rb_data (cfg.rb_data),
        .rb_valid(cfg.rb_valid)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: two loaders (19-bit and 16-bit chains) with behavioural
// chain models on their heads/tails, checked against a word/bit-stream model.
module tb_ccff_chain_loader;
    localparam int W    = 16;
    localparam int CL_A = 19;
    localparam int CL_B = 16;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic pReset;
    logic start_a, abort_a, tail_a, head_a, se_a, busy_a, done_a;
    logic start_b, abort_b, tail_b, head_b, se_b, busy_b, done_b;
    logic [CL_A-1:0] chain_a;
    logic [CL_B-1:0] chain_b;

    ccff_chain_loader_if #(.WORD_W(W)) bus_a ();
    ccff_chain_loader_if #(.WORD_W(W)) bus_b ();

    ccff_chain_loader #(.CHAIN_LEN(CL_A), .WORD_W(W)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .abort(abort_a),
        .cfg(bus_a), .ccff_head(head_a), .chain_shift_en(se_a),
        .ccff_tail(tail_a), .busy(busy_a), .done(done_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(CL_B), .WORD_W(W)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .abort(abort_b),
        .cfg(bus_b), .ccff_head(head_b), .chain_shift_en(se_b),
        .ccff_tail(tail_b), .busy(busy_b), .done(done_b)
    );

    assign tail_a = chain_a[CL_A-1];
    assign tail_b = chain_b[CL_B-1];

    int n_vec = 0;
    int n_err = 0;
    bit sel_b = 1'b0;

    logic          m_se, m_head, m_ready, m_rbv, m_done, m_busy;
    logic [W-1:0]  m_rb;
    always_comb begin
        if (sel_b) begin
            m_se = se_b; m_head = head_b; m_ready = bus_b.cfg_ready;
            m_rbv = bus_b.rb_valid; m_rb = bus_b.rb_data; m_done = done_b; m_busy = busy_b;
        end else begin
            m_se = se_a; m_head = head_a; m_ready = bus_a.cfg_ready;
            m_rbv = bus_a.rb_valid; m_rb = bus_a.rb_data; m_done = done_a; m_busy = busy_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic vl, input logic [W-1:0] d);
        if (sel_b) begin
            start_b = st; abort_b = ab; bus_b.cfg_valid = vl; bus_b.cfg_data = d;
        end else begin
            start_a = st; abort_a = ab; bus_a.cfg_valid = vl; bus_a.cfg_data = d;
        end
    endtask

    // One clock: chain models shift on edges where their shift enable was high.
    task automatic step();
        logic sa, ha, sb, hb;
        sa = se_a; ha = head_a; sb = se_b; hb = head_b;
        @(posedge prog_clk);
        #1;
        if (sa) chain_a = {chain_a[CL_A-2:0], ha};
        if (sb) chain_b = {chain_b[CL_B-2:0], hb};
        @(negedge prog_clk);
    endtask

    task automatic do_load(input int cl, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int gap_pct, input int hold, input int abort_bit,
                           output logic [W-1:0] rb0, output logic [W-1:0] rb1);
        logic [CL_A-1:0] old, exp_chain, cur_chain;
        logic [W-1:0]    words [2];
        logic [W-1:0]    rb_exp [2];
        logic [W-1:0]    rb_got [2];
        logic [W-1:0]    data;
        int  nw, k, r, wi, cyc;
        bit  fin, aborted, hs, vl, st, ab;
        nw = (cl + W - 1) / W;
        old = sel_b ? CL_A'(chain_b) : chain_a;
        words[0] = w0; words[1] = w1;
        rb_exp[0] = '0; rb_exp[1] = '0;
        rb_got[0] = '0; rb_got[1] = '0;
        exp_chain = '0;
        for (int i = 0; i < cl; i++) begin
            rb_exp[i / W][W - 1 - (i % W)] = old[cl - 1 - i];
            exp_chain[cl - 1 - i] = words[i / W][W - 1 - (i % W)];
        end

        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        cyc = 1;
        check("ready_after_start", 32'(m_ready), 32'd1);
        for (int i = 0; i < hold; i++) begin
            drive(1'b0, 1'b0, 1'b0, W'($urandom));
            step();
            cyc++;
            check("hold_no_shift", 32'(m_se), 32'd0);
            check("hold_ready", 32'(m_ready), 32'd1);
        end

        k = 0; r = 0; wi = 0; fin = 0; aborted = 0;
        while (!fin && cyc < 300) begin
            ab = 0;
            if (m_se) begin
                check("head_bit", 32'(m_head), 32'(words[k / W][W - 1 - (k % W)]));
                if (k == abort_bit) ab = 1;
                k++;
            end
            if (m_rbv) begin
                if (r < 2) begin
                    rb_got[r] = m_rb;
                    check("rb_word", 32'(m_rb), 32'(rb_exp[r]));
                end
                r++;
            end
            if (m_done) begin
                fin = 1;
            end else if (ab) begin
                drive(1'b0, 1'b1, 1'b1, W'($urandom));
                step();
                check("abort_shift_en", 32'(m_se), 32'd0);
                check("abort_ready", 32'(m_ready), 32'd0);
                check("abort_busy", 32'(m_busy), 32'd0);
                check("abort_done", 32'(m_done), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    drive(1'b0, 1'b0, 1'b0, '0);
                    step();
                    check("abort_no_rb", 32'(m_rbv), 32'd0);
                    check("abort_idle", 32'({m_busy, m_done, m_se}), 32'd0);
                end
                aborted = 1;
                break;
            end else begin
                vl   = ($urandom_range(99) >= gap_pct);
                st   = m_busy && ($urandom_range(3) == 0);
                data = (wi < nw) ? words[wi] : W'($urandom);
                hs   = vl && m_ready;
                drive(st, 1'b0, vl, data);
                step();
                cyc++;
                if (hs) wi++;
            end
        end

        if (!aborted) begin
            cur_chain = sel_b ? CL_A'(chain_b) : chain_a;
            check("load_finished", 32'(fin), 32'd1);
            check("shift_count", k, cl);
            check("rb_count", r, nw);
            check("words_used", wi, nw);
            check("chain_contents", 32'(cur_chain), 32'(exp_chain));
            check("busy_in_done", 32'(m_busy), 32'd0);
            if (gap_pct == 0 && hold == 0) check("start_to_done", cyc, cl + nw + 1);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        rb0 = rb_got[0];
        rb1 = rb_got[1];
    endtask

    logic [W-1:0] rb0, rb1;

    initial begin
        pReset = 1'b1;
        start_a = 0; abort_a = 0; bus_a.cfg_valid = 0; bus_a.cfg_data = '0;
        start_b = 0; abort_b = 0; bus_b.cfg_valid = 0; bus_b.cfg_data = '0;
        chain_a = '0; chain_b = '0;
        @(negedge prog_clk);
        @(negedge prog_clk);
        check("rst_a_outs", 32'({head_a, se_a, bus_a.cfg_ready, bus_a.rb_valid, busy_a, done_a}), 32'd0);
        check("rst_a_rb_data", 32'(bus_a.rb_data), 32'd0);
        check("rst_b_outs", 32'({head_b, se_b, bus_b.cfg_ready, bus_b.rb_valid, busy_b, done_b}), 32'd0);
        pReset = 1'b0;
        step();

        // Asynchronous reset in the middle of a shift.
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        check("mid_shift_active", 32'(se_a), 32'd1);
        #2 pReset = 1'b1;
        #1;
        check("async_rst_outs", 32'({head_a, se_a, bus_a.cfg_ready, bus_a.rb_valid, busy_a, done_a}), 32'd0);
        check("async_rst_rb_data", 32'(bus_a.rb_data), 32'd0);
        #1 pReset = 1'b0;
        @(negedge prog_clk);
        check("idle_after_rst", 32'({bus_a.cfg_ready, busy_a}), 32'd0);

        // Directed full load with the reference words.
        do_load(CL_A, 16'hA5C3, 16'hE000, 0, 0, -1, rb0, rb1);

        // Readback of a known preload.
        chain_a = 19'h5_5555;
        do_load(CL_A, W'($urandom), W'($urandom), 0, 0, -1, rb0, rb1);
        check("rb0_const", 32'(rb0), 32'h0000_AAAA);
        check("rb1_const", 32'(rb1), 32'h0000_A000);

        // Backpressure in WAIT_WORD plus random gaps.
        do_load(CL_A, W'($urandom), W'($urandom), 30, 5, -1, rb0, rb1);

        // abort together with start, from DONE and from IDLE.
        drive(1'b1, 1'b1, 1'b1, W'($urandom));
        step();
        check("abort_start_done", 32'({done_a, busy_a, bus_a.cfg_ready}), 32'd0);
        drive(1'b1, 1'b1, 1'b1, W'($urandom));
        step();
        drive(1'b0, 1'b0, 1'b1, W'($urandom));
        step();
        check("abort_start_idle", 32'({done_a, busy_a, bus_a.cfg_ready, se_a}), 32'd0);

        // Abort at bit 7, then full reloads with random data and gaps.
        do_load(CL_A, W'($urandom), W'($urandom), 0, 0, 7, rb0, rb1);
        for (int n = 0; n < 5; n++) begin
            do_load(CL_A, W'($urandom), W'($urandom), 40, 0, -1, rb0, rb1);
        end

        // Single-word chain: no pad, back-to-back loads restarted from DONE.
        sel_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        chain_b = 16'h1234;
        do_load(CL_B, 16'hBEEF, '0, 0, 0, -1, rb0, rb1);
        check("b_rb_const", 32'(rb0), 32'h0000_1234);
        for (int n = 0; n < 4; n++) begin
            do_load(CL_B, W'($urandom), '0, 30, 0, -1, rb0, rb1);
        end
        do_load(CL_B, W'($urandom), '0, 0, 0, 7, rb0, rb1);
        do_load(CL_B, W'($urandom), '0, 0, 2, -1, rb0, rb1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
